// File: rtl/hash_arbiter.sv
// hash_arbiter
//   Shares one SHAKE core (hash_mem_interface) among NUM_REQ hash requesters.
//   Start pulses are queued as per-slice pending bits; the core is granted
//   round-robin starting after the previous owner and held until the owner
//   completes its force_done / force_done_ack handshake.
//
//   Ports (requester side, slice k of each packed bus belongs to requester k):
//     i_req_data_in, i_req_data_out_ready, i_req_input_length,
//     i_req_output_length, i_req_start, i_req_force_done      requester -> arb
//     o_req_addr, o_req_rd_en, o_req_data_out_valid,
//     o_req_force_done_ack                                    arb -> owner only
//     o_req_data_out                                          broadcast digest
//   Ports (core side): o_hash_* drive the core inputs, i_hash_* are the core
//     outputs; o_hash_start is a 1-cycle pulse, lengths are held for the job.
//   Status: o_grant (one-hot owner, 0 when idle), o_overrun (1-cycle pulse
//     when a start arrives from a slice that is already pending or owning).
//
//   Timing: start sampled on edge N -> grant on edge N+1 -> o_hash_start high
//   for the cycle after that edge (core samples it on edge N+2).

// Per-requester queue slot: pending flag, latched lengths and overrun pulse.
module hash_arbiter_slot #(
    parameter int LEN_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_owned,     // granted and not yet in release
    input  logic             i_take,      // arbiter grants this slot now
    input  logic [LEN_W-1:0] i_in_len,
    input  logic [LEN_W-1:0] i_out_len,
    output logic             o_pending,
    output logic             o_overrun,
    output logic [LEN_W-1:0] o_in_len,
    output logic [LEN_W-1:0] o_out_len
);
    logic accept;

    // A start while the slot is already queued or running is dropped; the
    // requester sees the overrun pulse instead.
    assign accept = i_start && !o_pending && !i_owned;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pending <= 1'b0;
            o_overrun <= 1'b0;
            o_in_len  <= '0;
            o_out_len <= '0;
        end else begin
            o_overrun <= i_start && !accept;
            if (accept) begin
                o_pending <= 1'b1;
                o_in_len  <= i_in_len;
                o_out_len <= i_out_len;
            end else if (i_take) begin
                o_pending <= 1'b0;
            end
        end
    end
endmodule

module hash_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int IO_WIDTH = 32,
    parameter int ADDR_W   = 12,
    parameter int LEN_W    = 32
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [NUM_REQ-1:0][IO_WIDTH-1:0]   i_req_data_in,
    output logic [NUM_REQ-1:0][ADDR_W-1:0]     o_req_addr,
    output logic [NUM_REQ-1:0]                 o_req_rd_en,
    output logic [NUM_REQ-1:0][IO_WIDTH-1:0]   o_req_data_out,
    output logic [NUM_REQ-1:0]                 o_req_data_out_valid,
    input  logic [NUM_REQ-1:0]                 i_req_data_out_ready,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]      i_req_input_length,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]      i_req_output_length,
    input  logic [NUM_REQ-1:0]                 i_req_start,
    input  logic [NUM_REQ-1:0]                 i_req_force_done,
    output logic [NUM_REQ-1:0]                 o_req_force_done_ack,
    output logic [IO_WIDTH-1:0]                o_hash_data_in,
    input  logic [ADDR_W-1:0]                  i_hash_addr,
    input  logic                               i_hash_rd_en,
    input  logic [IO_WIDTH-1:0]                i_hash_data_out,
    input  logic                               i_hash_data_out_valid,
    output logic                               o_hash_data_out_ready,
    output logic [LEN_W-1:0]                   o_hash_input_length,
    output logic [LEN_W-1:0]                   o_hash_output_length,
    output logic                               o_hash_start,
    output logic                               o_hash_force_done,
    input  logic                               i_hash_force_done_ack,
    output logic [NUM_REQ-1:0]                 o_grant,
    output logic [NUM_REQ-1:0]                 o_overrun
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RELEASE} state_t;

    state_t                         state_q, state_d;
    logic [NUM_REQ-1:0]             grant_q;
    logic [IDX_W-1:0]               gidx_q, last_q;
    logic [LEN_W-1:0]               core_in_len_q, core_out_len_q;
    logic [NUM_REQ-1:0]             pending, owned, take;
    logic [NUM_REQ-1:0][LEN_W-1:0]  lat_in_len, lat_out_len;
    logic [IDX_W-1:0]               pick_idx, cand;
    logic                           pick_vld, route, do_grant, do_release;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
        hash_arbiter_slot #(.LEN_W(LEN_W)) u_slot (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_start   (i_req_start[k]),
            .i_owned   (owned[k]),
            .i_take    (take[k]),
            .i_in_len  (i_req_input_length[k]),
            .i_out_len (i_req_output_length[k]),
            .o_pending (pending[k]),
            .o_overrun (o_overrun[k]),
            .o_in_len  (lat_in_len[k]),
            .o_out_len (lat_out_len[k])
        );
    end

    // Once the owner is in release its job is over, so a fresh start from it
    // is queued rather than flagged.
    assign owned = (state_q == S_RELEASE) ? '0 : grant_q;

    // Round-robin: scan last+1 .. last+NUM_REQ; the descending loop leaves the
    // nearest pending slice in pick_idx.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (pending[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign do_grant   = (state_q == S_IDLE) && pick_vld;
    assign do_release = (state_q == S_RELEASE) && !i_req_force_done[gidx_q];
    assign take       = do_grant ? (NUM_REQ'(1) << pick_idx) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (pick_vld) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_BUSY;
            S_BUSY:    if (i_hash_force_done_ack && i_req_force_done[gidx_q]) state_d = S_RELEASE;
            S_RELEASE: if (!i_req_force_done[gidx_q]) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            grant_q        <= '0;
            gidx_q         <= '0;
            last_q         <= IDX_W'(NUM_REQ - 1);
            core_in_len_q  <= '0;
            core_out_len_q <= '0;
        end else begin
            state_q <= state_d;
            if (do_grant) begin
                grant_q        <= NUM_REQ'(1) << pick_idx;
                gidx_q         <= pick_idx;
                core_in_len_q  <= lat_in_len[pick_idx];
                core_out_len_q <= lat_out_len[pick_idx];
            end else if (do_release) begin
                grant_q        <= '0;
                last_q         <= gidx_q;
                core_in_len_q  <= '0;
                core_out_len_q <= '0;
            end
        end
    end

    // The core is only connected to the owner after the start pulse; during
    // release force_done stays asserted towards the core until the owner lets
    // go of its own force_done.
    assign route = (state_q == S_BUSY) || (state_q == S_RELEASE);

    always_comb begin
        o_req_addr            = '0;
        o_req_rd_en           = '0;
        o_req_data_out_valid  = '0;
        o_req_force_done_ack  = '0;
        o_hash_data_in        = '0;
        o_hash_data_out_ready = 1'b0;
        o_hash_force_done     = 1'b0;
        if (route) begin
            o_req_addr[gidx_q]           = i_hash_addr;
            o_req_rd_en[gidx_q]          = i_hash_rd_en;
            o_req_data_out_valid[gidx_q] = i_hash_data_out_valid;
            o_req_force_done_ack[gidx_q] = i_hash_force_done_ack;
            o_hash_data_in               = i_req_data_in[gidx_q];
            o_hash_data_out_ready        = i_req_data_out_ready[gidx_q];
            o_hash_force_done            = (state_q == S_RELEASE) || i_req_force_done[gidx_q];
        end
    end

    assign o_req_data_out       = {NUM_REQ{i_hash_data_out}};
    assign o_hash_start         = (state_q == S_ISSUE);
    assign o_hash_input_length  = core_in_len_q;
    assign o_hash_output_length = core_out_len_q;
    assign o_grant              = grant_q;
endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter: directed scenarios plus randomized traffic against a
// job-level reference model (queue of pending requesters, current owner,
// round-robin pick by modular arithmetic). The bench plays both the core and
// the requesters.
module tb_hash_arbiter;
    localparam int NUM_REQ  = 3;
    localparam int IO_WIDTH = 32;
    localparam int ADDR_W   = 12;
    localparam int LEN_W    = 32;

    logic                              i_clk = 1'b0;
    logic                              i_rst_n;
    logic [NUM_REQ-1:0][IO_WIDTH-1:0]  i_req_data_in;
    logic [NUM_REQ-1:0][ADDR_W-1:0]    o_req_addr;
    logic [NUM_REQ-1:0]                o_req_rd_en;
    logic [NUM_REQ-1:0][IO_WIDTH-1:0]  o_req_data_out;
    logic [NUM_REQ-1:0]                o_req_data_out_valid;
    logic [NUM_REQ-1:0]                i_req_data_out_ready;
    logic [NUM_REQ-1:0][LEN_W-1:0]     i_req_input_length;
    logic [NUM_REQ-1:0][LEN_W-1:0]     i_req_output_length;
    logic [NUM_REQ-1:0]                i_req_start;
    logic [NUM_REQ-1:0]                i_req_force_done;
    logic [NUM_REQ-1:0]                o_req_force_done_ack;
    logic [IO_WIDTH-1:0]               o_hash_data_in;
    logic [ADDR_W-1:0]                 i_hash_addr;
    logic                              i_hash_rd_en;
    logic [IO_WIDTH-1:0]               i_hash_data_out;
    logic                              i_hash_data_out_valid;
    logic                              o_hash_data_out_ready;
    logic [LEN_W-1:0]                  o_hash_input_length;
    logic [LEN_W-1:0]                  o_hash_output_length;
    logic                              o_hash_start;
    logic                              o_hash_force_done;
    logic                              i_hash_force_done_ack;
    logic [NUM_REQ-1:0]                o_grant;
    logic [NUM_REQ-1:0]                o_overrun;

    hash_arbiter #(.NUM_REQ(NUM_REQ), .IO_WIDTH(IO_WIDTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_data_in(i_req_data_in), .o_req_addr(o_req_addr), .o_req_rd_en(o_req_rd_en),
        .o_req_data_out(o_req_data_out), .o_req_data_out_valid(o_req_data_out_valid),
        .i_req_data_out_ready(i_req_data_out_ready), .i_req_input_length(i_req_input_length),
        .i_req_output_length(i_req_output_length), .i_req_start(i_req_start),
        .i_req_force_done(i_req_force_done), .o_req_force_done_ack(o_req_force_done_ack),
        .o_hash_data_in(o_hash_data_in), .i_hash_addr(i_hash_addr), .i_hash_rd_en(i_hash_rd_en),
        .i_hash_data_out(i_hash_data_out), .i_hash_data_out_valid(i_hash_data_out_valid),
        .o_hash_data_out_ready(o_hash_data_out_ready), .o_hash_input_length(o_hash_input_length),
        .o_hash_output_length(o_hash_output_length), .o_hash_start(o_hash_start),
        .o_hash_force_done(o_hash_force_done), .i_hash_force_done_ack(i_hash_force_done_ack),
        .o_grant(o_grant), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: who owns the core, whether it has finished
    // (release phase), whether this is its start cycle, and the queue.
    int                 owner, last, busy_cnt, target;
    bit                 issue, rel, fd_prev, len_fix;
    bit [NUM_REQ-1:0]   pend, exp_ovr;
    logic [LEN_W-1:0]   lat_in [NUM_REQ];
    logic [LEN_W-1:0]   lat_out[NUM_REQ];
    logic [LEN_W-1:0]   core_in, core_out, fix_in, fix_out;
    logic [NUM_REQ-1:0] prev_grant;
    int                 obs_q[$];
    int                 ovr0_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; last = NUM_REQ - 1; busy_cnt = 0; target = 3;
        issue = 0; rel = 0; fd_prev = 0; pend = '0; exp_ovr = '0;
        core_in = '0; core_out = '0; prev_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin lat_in[k] = '0; lat_out[k] = '0; end
    endtask

    task automatic zero_inputs();
        i_req_data_in = '0; i_req_data_out_ready = '0; i_req_input_length = '0;
        i_req_output_length = '0; i_req_start = '0; i_req_force_done = '0;
        i_hash_addr = '0; i_hash_rd_en = 0; i_hash_data_out = '0;
        i_hash_data_out_valid = 0; i_hash_force_done_ack = 0;
    endtask

    // Effect of one clock edge on the job-level model, using the inputs that
    // were held during the cycle.
    task automatic model_edge();
        bit [NUM_REQ-1:0] ovr;
        for (int k = 0; k < NUM_REQ; k++)
            ovr[k] = i_req_start[k] && (pend[k] || (owner == k && !rel));
        if (owner >= 0) begin
            if (issue) issue = 0;
            else if (!rel && i_hash_force_done_ack && i_req_force_done[owner]) rel = 1;
            else if (rel && !i_req_force_done[owner]) begin
                last = owner; owner = -1; rel = 0; core_in = '0; core_out = '0;
            end
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                int c = (last + i) % NUM_REQ;
                if (pend[c]) begin owner = c; break; end
            end
            if (owner >= 0) begin
                pend[owner] = 0; issue = 1; busy_cnt = 0;
                target = $urandom_range(3, 6);
                core_in = lat_in[owner]; core_out = lat_out[owner];
            end
        end
        for (int k = 0; k < NUM_REQ; k++)
            if (i_req_start[k] && !ovr[k]) begin
                pend[k] = 1; lat_in[k] = i_req_input_length[k]; lat_out[k] = i_req_output_length[k];
            end
        exp_ovr = ovr;
    endtask

    // One clock cycle: drive at negedge, check outputs 1 time unit later,
    // advance the model at posedge.
    task automatic step(input logic [NUM_REQ-1:0] st);
        logic [NUM_REQ-1:0]             e_rd, e_vld, e_ack, e_grant;
        logic [NUM_REQ-1:0][ADDR_W-1:0] e_addr;
        logic [IO_WIDTH-1:0]            e_din;
        logic                           e_rdy, e_fd;
        bit                             routed;
        @(negedge i_clk);
        i_req_start = st;
        for (int k = 0; k < NUM_REQ; k++) begin
            i_req_input_length[k]   = len_fix ? fix_in  : LEN_W'($urandom);
            i_req_output_length[k]  = len_fix ? fix_out : LEN_W'($urandom);
            i_req_data_in[k]        = IO_WIDTH'($urandom);
            i_req_data_out_ready[k] = 1'($urandom);
            i_req_force_done[k]     = (k != owner) && ($urandom_range(0, 7) == 0);
        end
        if (owner >= 0 && !issue && !rel) busy_cnt++;
        if (owner >= 0) i_req_force_done[owner] = !issue && !rel && busy_cnt >= target;
        i_hash_addr           = ADDR_W'($urandom);
        i_hash_rd_en          = 1'($urandom);
        i_hash_data_out       = IO_WIDTH'($urandom);
        i_hash_data_out_valid = 1'($urandom);
        i_hash_force_done_ack = fd_prev;   // core acks one cycle after force_done
        #1;
        routed = (owner >= 0) && !issue;
        e_grant = (owner >= 0) ? (NUM_REQ'(1) << owner) : '0;
        e_rd = '0; e_vld = '0; e_ack = '0; e_addr = '0; e_din = '0; e_rdy = 0; e_fd = 0;
        if (routed) begin
            e_rd[owner]   = i_hash_rd_en;
            e_vld[owner]  = i_hash_data_out_valid;
            e_ack[owner]  = i_hash_force_done_ack;
            e_addr[owner] = i_hash_addr;
            e_din         = i_req_data_in[owner];
            e_rdy         = i_req_data_out_ready[owner];
            e_fd          = rel || i_req_force_done[owner];
        end
        chk("grant",      128'(o_grant), 128'(e_grant));
        chk("overrun",    128'(o_overrun), 128'(exp_ovr));
        chk("hash_start", 128'(o_hash_start), 128'(issue));
        chk("in_len",     128'(o_hash_input_length), 128'(core_in));
        chk("out_len",    128'(o_hash_output_length), 128'(core_out));
        chk("rd_en",      128'(o_req_rd_en), 128'(e_rd));
        chk("dout_valid", 128'(o_req_data_out_valid), 128'(e_vld));
        chk("fd_ack",     128'(o_req_force_done_ack), 128'(e_ack));
        chk("addr",       128'(o_req_addr), 128'(e_addr));
        chk("data_in",    128'(o_hash_data_in), 128'(e_din));
        chk("dout_ready", 128'(o_hash_data_out_ready), 128'(e_rdy));
        chk("force_done", 128'(o_hash_force_done), 128'(e_fd));
        chk("data_out",   128'(o_req_data_out), 128'({NUM_REQ{i_hash_data_out}}));
        if (o_grant != '0 && o_grant != prev_grant)
            for (int k = 0; k < NUM_REQ; k++) if (o_grant[k]) obs_q.push_back(k);
        prev_grant = o_grant;
        if (o_overrun[0]) ovr0_cnt++;
        fd_prev = e_fd;
        @(posedge i_clk);
        model_edge();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((owner >= 0 || pend != '0) && n < 400) begin step('0); n++; end
        chk(tag, 128'(n >= 400), 128'(0));
        step('0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        len_fix = 0; fix_in = '0; fix_out = '0; ovr0_cnt = 0;
        zero_inputs();
        model_reset();
        i_rst_n = 0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_grant", 128'(o_grant), 128'(0));
        chk("rst_start", 128'(o_hash_start), 128'(0));
        chk("rst_fd",    128'(o_hash_force_done), 128'(0));
        chk("rst_len",   128'(o_hash_input_length), 128'(0));
        chk("rst_ovr",   128'(o_overrun), 128'(0));
        i_rst_n = 1;

        // Simultaneous starts after reset: 0,1,2, then again 0,1,2.
        obs_q.delete();
        step(3'b111); drain("sim_drain1");
        step(3'b111); drain("sim_drain2");
        chk("sim_count", 128'(obs_q.size()), 128'(6));
        for (int i = 0; i < 6 && i < obs_q.size(); i++)
            chk("sim_order", 128'(obs_q[i]), 128'(i % 3));

        // Single request on slice 1 with fixed lengths.
        len_fix = 1; fix_in = 32'h1000; fix_out = 32'd256;
        step(3'b010);
        len_fix = 0;
        #1 chk("s1_grant_wait", 128'(o_grant), 128'(0));
        step('0);
        #1 chk("s1_grant", 128'(o_grant), 128'(3'b010));
        chk("s1_start", 128'(o_hash_start), 128'(1));
        chk("s1_in_len", 128'(o_hash_input_length), 128'(32'h1000));
        chk("s1_out_len", 128'(o_hash_output_length), 128'(256));
        step('0);
        #1 chk("s1_start_end", 128'(o_hash_start), 128'(0));
        drain("s1_drain");

        // Slice 2 busy, slice 0 starts twice: one overrun, served once after 2.
        obs_q.delete(); ovr0_cnt = 0;
        step(3'b100);
        n = 0;
        while (owner != 2 && n < 10) begin step('0); n++; end
        step(3'b001); step('0); step(3'b001);
        drain("ovr_drain");
        chk("ovr_pulses", 128'(ovr0_cnt), 128'(1));
        chk("ovr_count", 128'(obs_q.size()), 128'(2));
        if (obs_q.size() == 2) begin
            chk("ovr_first", 128'(obs_q[0]), 128'(2));
            chk("ovr_second", 128'(obs_q[1]), 128'(0));
        end

        // Reset while slice 2 is busy with slices 0 and 1 pending.
        step(3'b100);
        n = 0;
        while (!(owner == 2 && !issue) && n < 10) begin step('0); n++; end
        step(3'b011); step('0);
        @(negedge i_clk); #2;
        i_rst_n = 0;
        #1;
        chk("mid_rst_grant", 128'(o_grant), 128'(0));
        chk("mid_rst_start", 128'(o_hash_start), 128'(0));
        chk("mid_rst_fd",    128'(o_hash_force_done), 128'(0));
        chk("mid_rst_rd_en", 128'(o_req_rd_en), 128'(0));
        chk("mid_rst_ack",   128'(o_req_force_done_ack), 128'(0));
        chk("mid_rst_din",   128'(o_hash_data_in), 128'(0));
        chk("mid_rst_len",   128'(o_hash_input_length), 128'(0));
        model_reset();
        zero_inputs();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1;
        repeat (5) step('0);
        #1 chk("mid_rst_no_restart", 128'(o_grant), 128'(0));

        // Random traffic.
        for (int c = 0; c < 2500; c++) begin
            logic [NUM_REQ-1:0] st;
            for (int k = 0; k < NUM_REQ; k++) st[k] = ($urandom_range(0, 5) == 0);
            step(st);
        end
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
